l1_cache: RTL and testbench
===========================

// Module: l1_cache
// PURPOSE
//  Direct-mapped, write-back, write-allocate cache between the mp3 core memory port
//  (arbiter output) and physical memory. It turns 16-bit word requests into 128-bit
//  line transfers. Hits are answered the same cycle; misses stall the core.
// PARAMETERS
//  NUM_SETS  8  number of lines; power of two, >=2. IDX_W = log2(NUM_SETS).
//  Line size is fixed at 16 bytes: offset = addr[3:0], index = addr[3+IDX_W:4],
//  tag = addr[15:4+IDX_W].
// PORTS
//  clk              in   1    single clock, rising edge
//  reset            in   1    asynchronous, active-high
//  mem_read         in   1    core read request; held until mem_resp
//  mem_write        in   1    core write request; held until mem_resp
//  mem_byte_enable  in   2    [0] = low byte, [1] = high byte of write word
//  mem_address      in   16   byte address; bit 0 ignored (word aligned)
//  mem_wdata        in   16   write data
//  mem_rdata        out  16   read word; valid only while mem_resp=1
//  mem_resp         out  1    request complete, 1-cycle pulse per request
//  pmem_read        out  1    line fill request; held until pmem_resp
//  pmem_write       out  1    line writeback request; held until pmem_resp
//  pmem_address     out  16   line address, bits [3:0] always 0
//  pmem_wdata       out  128  writeback line data
//  pmem_rdata       in   128  fill line data; valid with pmem_resp
//  pmem_resp        in   1    physical transfer complete
// BEHAVIOUR
//  - State: valid[NUM_SETS], dirty[NUM_SETS], tag[NUM_SETS], data[NUM_SETS][128].
//    Only valid, dirty and FSM state are reset. data and tag are not reset.
//  - Reset (async): state=IDLE, all valid=0, all dirty=0. mem_resp, pmem_read,
//    pmem_write = 0; pmem_address = 0; pmem_wdata = 0. Outputs go to these values
//    immediately, not at the next edge.
//  - FSM states: IDLE, WRITEBACK, FETCH.
//    IDLE: hit = valid[idx] && tag[idx]==req_tag.
//      * Request + hit: mem_resp=1 combinationally in the same cycle (0 wait states).
//      * Read hit: mem_rdata = word addr[3:1] of the line.
//      * Write hit: at the clock edge, enabled bytes are written. dirty[idx] is set
//        only if mem_byte_enable != 0.
//      * Request + miss + !dirty[idx] -> FETCH.
//      * Request + miss + valid && dirty -> WRITEBACK.
//    WRITEBACK: pmem_write=1, pmem_address={tag[idx],idx,4'b0}, pmem_wdata=data[idx].
//      On pmem_resp -> FETCH.
//    FETCH: pmem_read=1, pmem_address={req_tag,idx,4'b0}.
//      On pmem_resp: data[idx]=pmem_rdata, tag[idx]=req_tag, valid=1, dirty=0 -> IDLE.
//      IDLE then re-evaluates and hits, so a miss costs fill (+writeback) + 1 cycle.
//  - Outside their states: pmem_read=pmem_write=0, pmem_address=0, pmem_wdata=0.
//  - pmem_resp is ignored in IDLE. mem_resp is never asserted in WRITEBACK or FETCH.
//  - mem_read && mem_write both set is illegal. The cache services it as a read
//    and performs no write.
//  - Request fields are sampled live. The requester must hold them stable until
//    mem_resp. Dropping a request mid-miss still completes the line fill.
//  - Reset during WRITEBACK or FETCH aborts the transfer. No array update occurs.
//    Memory may be left partially written; that is acceptable.
// TESTING
//  1. Reset; read 0x0040 -> pmem_read=1, pmem_address=0x0040. Return line with
//     word0=0x1234 -> next cycle mem_resp=1, mem_rdata=0x1234. Re-read 0x0040 ->
//     mem_resp in the same cycle with no pmem_read.
//  2. After test 1, write 0x0042 data 0xABCD with be=2'b01 -> mem_resp same cycle.
//     Read 0x0042 returns {old_hi, 8'hCD}; dirty[4]=1.
//  3. Dirty set 4, then read 0x0440 -> pmem_write with address 0x0040 and the
//     modified line. After pmem_resp: pmem_read with address 0x0440. Then mem_resp.
//  4. Assert reset while in FETCH -> pmem_read drops the same cycle. A later read of
//     the same address misses again (valid cleared).
//  5. Write with be=2'b00 on a clean hit -> mem_resp=1; line and dirty unchanged.
//     A conflict miss then goes straight to FETCH (no writeback).
//  6. Read 0xFFFE (set 7, max tag) after a fill -> mem_rdata = line word 7.
//     pmem_address=0xFFF0.

Source files
------------

// File: rtl/l1_cache_if.sv
// Bus interfaces for the L1 cache: core-side word port and physical-memory line port.
// Core port: the core is master, the cache is slave. Memory port: the cache is master.

interface l1_cache_if;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_resp;

  modport master (
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  mem_rdata, mem_resp
  );

  modport slave (
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output mem_rdata, mem_resp
  );
endinterface

interface l1_pmem_if;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/l1_cache.sv
// Direct-mapped, write-back, write-allocate L1 cache with 16-byte lines.
// Hits answer in the same cycle; misses stall the core through WRITEBACK/FETCH.

module l1_cache #(
  parameter int NUM_SETS = 8
) (
  input  logic      clk,
  input  logic      reset,
  l1_cache_if.slave core,
  l1_pmem_if.master pmem
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 12 - IDX_W;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FETCH
  } state_t;

  state_t              state;
  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [127:0]        data_q [NUM_SETS];
  logic [11:0]         miss_line;

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [2:0]       word_sel;
  logic             req;
  logic             wr_op;
  logic             hit;
  logic             idle_hit;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic [127:0]     line_merged;

  assign req_idx  = core.mem_address[3+IDX_W:4];
  assign req_tag  = core.mem_address[15:4+IDX_W];
  assign word_sel = core.mem_address[3:1];
  assign req      = core.mem_read | core.mem_write;
  // A simultaneous read and write is serviced as a read only.
  assign wr_op    = core.mem_write & ~core.mem_read;
  assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign idle_hit = (state == IDLE) && req && hit;

  // The fill target comes from the registered line address so a dropped request still fills correctly.
  assign fill_idx = pmem.pmem_address[3+IDX_W:4];
  assign fill_tag = pmem.pmem_address[15:4+IDX_W];

  assign core.mem_resp  = idle_hit;
  assign core.mem_rdata = data_q[req_idx][{word_sel, 4'd0} +: 16];

  always_comb begin
    line_merged = data_q[req_idx];
    if (core.mem_byte_enable[0]) begin
      line_merged[{word_sel, 4'd0} +: 8] = core.mem_wdata[7:0];
    end
    if (core.mem_byte_enable[1]) begin
      line_merged[{word_sel, 4'd8} +: 8] = core.mem_wdata[15:8];
    end
  end

  // Control state and registered memory-side outputs; reset aborts any transfer in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      valid_q           <= '0;
      dirty_q           <= '0;
      miss_line         <= '0;
      pmem.pmem_read    <= 1'b0;
      pmem.pmem_write   <= 1'b0;
      pmem.pmem_address <= '0;
      pmem.pmem_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            if (hit) begin
              if (wr_op && (core.mem_byte_enable != 2'b00)) begin
                dirty_q[req_idx] <= 1'b1;
              end
            end else begin
              miss_line <= core.mem_address[15:4];
              if (valid_q[req_idx] && dirty_q[req_idx]) begin
                state             <= WRITEBACK;
                pmem.pmem_write   <= 1'b1;
                pmem.pmem_address <= {tag_q[req_idx], req_idx, 4'b0000};
                pmem.pmem_wdata   <= data_q[req_idx];
              end else begin
                state             <= FETCH;
                pmem.pmem_read    <= 1'b1;
                pmem.pmem_address <= {core.mem_address[15:4], 4'b0000};
              end
            end
          end
        end
        WRITEBACK: begin
          if (pmem.pmem_resp) begin
            state             <= FETCH;
            pmem.pmem_write   <= 1'b0;
            pmem.pmem_wdata   <= '0;
            pmem.pmem_read    <= 1'b1;
            pmem.pmem_address <= {miss_line, 4'b0000};
          end
        end
        FETCH: begin
          if (pmem.pmem_resp) begin
            state             <= IDLE;
            pmem.pmem_read    <= 1'b0;
            pmem.pmem_address <= '0;
            valid_q[fill_idx] <= 1'b1;
            dirty_q[fill_idx] <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line data and tags are not reset; an edge coinciding with reset must not update them.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if ((state == FETCH) && pmem.pmem_resp) begin
        data_q[fill_idx] <= pmem.pmem_rdata;
        tag_q[fill_idx]  <= fill_tag;
      end else if (idle_hit && wr_op) begin
        data_q[req_idx] <= line_merged;
      end
    end
  end

endmodule

// File: tb/tb_l1_cache.sv
// Self-checking bench for l1_cache: a flat memory image plus per-set presence model
// predicts every response, writeback and fill; directed cases pin the model with literals.

module tb_l1_cache;

  logic clk = 1'b0;
  logic reset;

  l1_cache_if core_bus ();
  l1_pmem_if  pmem_bus ();

  l1_cache #(.NUM_SETS(8)) dut (
    .clk  (clk),
    .reset(reset),
    .core (core_bus),
    .pmem (pmem_bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Architectural view of memory as the core must see it, and the backing line store.
  logic [15:0]  core_view [32768];
  logic [127:0] phys      [4096];

  // Which line each set holds, as implied by the access history.
  bit          m_valid [8];
  bit          m_dirty [8];
  logic [8:0]  m_tag   [8];

  int           resp_delay = 0;
  int           last_latency;
  logic [15:0]  last_rdata;
  logic [15:0]  last_fetch_addr;
  logic [15:0]  last_wb_addr;
  logic [127:0] last_wb_data;
  bit           last_wb;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] view_line(input logic [11:0] ln);
    logic [127:0] l;
    for (int w = 0; w < 8; w++) l[w*16 +: 16] = core_view[{ln, 3'(w)}];
    return l;
  endfunction

  function automatic int next_delay();
    if (resp_delay < 0) return $urandom_range(0, 3);
    return resp_delay;
  endfunction

  task automatic set_word(input logic [15:0] addr, input logic [15:0] val);
    core_view[addr[15:1]] = val;
    phys[addr[15:4]][addr[3:1]*16 +: 16] = val;
  endtask

  // Reset loses dirty data: the core view falls back to whatever memory holds.
  task automatic model_reset();
    logic [11:0] ln;
    for (int s = 0; s < 8; s++) begin
      if (m_valid[s] && m_dirty[s]) begin
        ln = {m_tag[s], 3'(s)};
        for (int w = 0; w < 8; w++) core_view[{ln, 3'(w)}] = phys[ln][w*16 +: 16];
      end
      m_valid[s] = 1'b0;
      m_dirty[s] = 1'b0;
    end
  endtask

  // Issue one request (called at posedge+1) and check every cycle until it completes.
  task automatic applyStimulus(input bit rd, input bit wr, input logic [15:0] addr,
                               input logic [1:0] be, input logic [15:0] wd);
    int          set;
    logic [8:0]  tg;
    logic [11:0] ln;
    logic [11:0] victim;
    int          phase;
    int          cnt;
    int          wait_n;
    bit          is_read;
    bit          is_write;
    set      = int'(addr[6:4]);
    tg       = addr[15:7];
    ln       = addr[15:4];
    victim   = {m_tag[set], addr[6:4]};
    is_read  = rd;
    is_write = wr && !rd;
    core_bus.mem_read        = rd;
    core_bus.mem_write       = wr;
    core_bus.mem_address     = addr;
    core_bus.mem_byte_enable = be;
    core_bus.mem_wdata       = wd;
    pmem_bus.pmem_resp       = 1'b0;
    last_wb = 1'b0;
    phase   = (m_valid[set] && m_tag[set] == tg) ? 3 : 0;
    cnt     = 0;
    wait_n  = next_delay();
    while (phase != 4) begin
      @(negedge clk);
      cnt++;
      if (cnt > 40) begin
        chk("req_timeout", 1'b1, 1'b0);
        phase = 4;
      end else begin
        case (phase)
          0: begin
            chk("miss_idle_resp", core_bus.mem_resp, 1'b0);
            chk("miss_idle_rw", {pmem_bus.pmem_read, pmem_bus.pmem_write}, 2'b00);
            phase = (m_valid[set] && m_dirty[set]) ? 1 : 2;
          end
          1: begin
            chk("wb_resp", core_bus.mem_resp, 1'b0);
            chk("wb_rw", {pmem_bus.pmem_read, pmem_bus.pmem_write}, 2'b01);
            chk("wb_addr", pmem_bus.pmem_address, {victim, 4'b0000});
            chk("wb_data", pmem_bus.pmem_wdata, view_line(victim));
            if (wait_n == 0) begin
              last_wb      = 1'b1;
              last_wb_addr = pmem_bus.pmem_address;
              last_wb_data = pmem_bus.pmem_wdata;
              pmem_bus.pmem_resp = 1'b1;
              @(posedge clk); #1;
              pmem_bus.pmem_resp = 1'b0;
              phys[victim] = last_wb_data;
              m_dirty[set] = 1'b0;
              phase  = 2;
              wait_n = next_delay();
            end else begin
              wait_n--;
            end
          end
          2: begin
            chk("fetch_resp", core_bus.mem_resp, 1'b0);
            chk("fetch_rw", {pmem_bus.pmem_read, pmem_bus.pmem_write}, 2'b10);
            chk("fetch_addr", pmem_bus.pmem_address, {ln, 4'b0000});
            if (wait_n == 0) begin
              last_fetch_addr     = pmem_bus.pmem_address;
              pmem_bus.pmem_rdata = phys[ln];
              pmem_bus.pmem_resp  = 1'b1;
              @(posedge clk); #1;
              pmem_bus.pmem_resp  = 1'b0;
              pmem_bus.pmem_rdata = {4{$urandom}};
              m_valid[set] = 1'b1;
              m_tag[set]   = tg;
              m_dirty[set] = 1'b0;
              phase = 3;
            end else begin
              pmem_bus.pmem_rdata = {4{$urandom}};
              wait_n--;
            end
          end
          default: begin
            chk("hit_resp", core_bus.mem_resp, 1'b1);
            chk("hit_rw", {pmem_bus.pmem_read, pmem_bus.pmem_write}, 2'b00);
            chk("hit_paddr", pmem_bus.pmem_address, 16'h0000);
            chk("hit_pwdata", pmem_bus.pmem_wdata, 128'h0);
            last_rdata = core_bus.mem_rdata;
            if (is_read) chk("rdata", core_bus.mem_rdata, core_view[addr[15:1]]);
            if (is_write) begin
              if (be[0]) core_view[addr[15:1]][7:0]  = wd[7:0];
              if (be[1]) core_view[addr[15:1]][15:8] = wd[15:8];
              if (be != 2'b00) m_dirty[set] = 1'b1;
            end
            last_latency = cnt;
            @(posedge clk); #1;
            phase = 4;
          end
        endcase
      end
    end
    core_bus.mem_read  = 1'b0;
    core_bus.mem_write = 1'b0;
  endtask

  // Quiet cycles with stray pmem_resp pulses that the idle cache must ignore.
  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      pmem_bus.pmem_resp  = 1'($urandom_range(0, 1));
      pmem_bus.pmem_rdata = {4{$urandom}};
      @(negedge clk);
      chk("idle_resp", core_bus.mem_resp, 1'b0);
      chk("idle_rw", {pmem_bus.pmem_read, pmem_bus.pmem_write}, 2'b00);
      chk("idle_paddr", pmem_bus.pmem_address, 16'h0000);
      @(posedge clk); #1;
    end
    pmem_bus.pmem_resp = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    chk(name, act, exp);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    bit found;
    logic [8:0] rtag;
    int r;
    reset = 1'b1;
    core_bus.mem_read        = 1'b0;
    core_bus.mem_write       = 1'b0;
    core_bus.mem_byte_enable = 2'b00;
    core_bus.mem_address     = 16'h0000;
    core_bus.mem_wdata       = 16'h0000;
    pmem_bus.pmem_resp       = 1'b0;
    pmem_bus.pmem_rdata      = '0;
    for (int l = 0; l < 4096; l++) begin
      phys[l] = {$urandom, $urandom, $urandom, $urandom};
      for (int w = 0; w < 8; w++) core_view[{12'(l), 3'(w)}] = phys[l][w*16 +: 16];
    end
    for (int s = 0; s < 8; s++) begin
      m_valid[s] = 1'b0;
      m_dirty[s] = 1'b0;
      m_tag[s]   = '0;
    end

    #12;
    checkOutput("reset_resp", core_bus.mem_resp, 1'b0);
    checkOutput("reset_rw", {pmem_bus.pmem_read, pmem_bus.pmem_write}, 2'b00);
    checkOutput("reset_paddr", pmem_bus.pmem_address, 16'h0000);
    checkOutput("reset_pwdata", pmem_bus.pmem_wdata, 128'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of a fill drops pmem_read at once and forgets the line.
    core_bus.mem_read    = 1'b1;
    core_bus.mem_address = 16'h0100;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (pmem_bus.pmem_read) found = 1'b1;
    end
    checkOutput("rst_fetch_seen", found, 1'b1);
    checkOutput("rst_fetch_addr", pmem_bus.pmem_address, 16'h0100);
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_fetch_drop", pmem_bus.pmem_read, 1'b0);
    checkOutput("rst_fetch_paddr", pmem_bus.pmem_address, 16'h0000);
    core_bus.mem_read = 1'b0;
    model_reset();
    @(posedge clk); #3 reset = 1'b0;
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, 16'h0100, 2'b00, 16'h0000);
    checkOutput("rst_refetch_lat", last_latency, 3);
    checkOutput("rst_refetch_addr", last_fetch_addr, 16'h0100);

    // Clean read miss, then a zero-wait hit.
    set_word(16'h0040, 16'h1234);
    set_word(16'h0042, 16'h5678);
    applyStimulus(1'b1, 1'b0, 16'h0040, 2'b00, 16'h0000);
    checkOutput("t1_lat", last_latency, 3);
    checkOutput("t1_rdata", last_rdata, 16'h1234);
    checkOutput("t1_faddr", last_fetch_addr, 16'h0040);
    applyStimulus(1'b1, 1'b0, 16'h0040, 2'b00, 16'h0000);
    checkOutput("t1_hit_lat", last_latency, 1);

    // Low-byte write hit.
    applyStimulus(1'b0, 1'b1, 16'h0042, 2'b01, 16'hABCD);
    checkOutput("t2_wlat", last_latency, 1);
    applyStimulus(1'b1, 1'b0, 16'h0042, 2'b00, 16'h0000);
    checkOutput("t2_rdata", last_rdata, 16'h56CD);

    // Dirty conflict: writeback of the modified line, then fill.
    applyStimulus(1'b1, 1'b0, 16'h0440, 2'b00, 16'h0000);
    checkOutput("t3_lat", last_latency, 4);
    checkOutput("t3_wb", last_wb, 1'b1);
    checkOutput("t3_wb_addr", last_wb_addr, 16'h0040);
    checkOutput("t3_wb_data", last_wb_data[31:0], 32'h56CD1234);
    checkOutput("t3_faddr", last_fetch_addr, 16'h0440);

    // Zero byte-enable write leaves the line clean; the next conflict skips writeback.
    applyStimulus(1'b0, 1'b1, 16'h0440, 2'b00, 16'hFFFF);
    checkOutput("t5_wlat", last_latency, 1);
    applyStimulus(1'b1, 1'b0, 16'h0040, 2'b00, 16'h0000);
    checkOutput("t5_lat", last_latency, 3);
    checkOutput("t5_nowb", last_wb, 1'b0);

    // Read and write together behave as a read.
    applyStimulus(1'b1, 1'b1, 16'h0040, 2'b11, 16'hDEAD);
    checkOutput("both_lat", last_latency, 1);
    applyStimulus(1'b1, 1'b0, 16'h0040, 2'b00, 16'h0000);
    checkOutput("both_nowrite", last_rdata, 16'h1234);

    // Top of the address space.
    set_word(16'hFFFE, 16'hBEEF);
    applyStimulus(1'b1, 1'b0, 16'hFFFE, 2'b00, 16'h0000);
    checkOutput("t6_rdata", last_rdata, 16'hBEEF);
    checkOutput("t6_faddr", last_fetch_addr, 16'hFFF0);

    // Randomised traffic over a few tags so hits, conflicts and writebacks all occur.
    resp_delay = -1;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0: rtag = 9'h000;
        1: rtag = 9'h001;
        2: rtag = 9'h002;
        default: rtag = 9'h1FF;
      endcase
      r = $urandom_range(0, 9);
      applyStimulus(r < 5 || r == 9, r >= 5,
                    {rtag, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1))},
                    2'($urandom_range(0, 3)), 16'($urandom));
      if ($urandom_range(0, 3) == 0) idle_gap($urandom_range(1, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
